// File: rtl/csi2_crc_check_if.sv
// Depacketised CSI-2 beat stream (4 byte lanes per beat) carried into the CRC checker.
interface csi2_crc_check_if;
    logic [31:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_sop;

    modport master (output pkt_data, output pkt_valid, output pkt_sop);
    modport slave  (input  pkt_data, input  pkt_valid, input  pkt_sop);
endinterface

// File: rtl/csi2_crc_check.sv
// CSI-2 long-packet CRC-16 checker: a passive sniffer that pulses ok/err/short/trunc flags.
// Define CSI2_CRC_CAPTURE_EN to keep the last failing computed/received CRC pair on calc_crc_o/rx_crc_o.
module csi2_crc_check #(
    parameter logic [15:0] CRC_INIT    = 16'hFFFF,
    parameter logic [5:0]  LONG_DT_MIN = 6'h10
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    csi2_crc_check_if.slave        pkt_if,
    output logic                   crc_err_o,
    output logic                   crc_ok_o,
    output logic                   short_pkt_o,
    output logic                   trunc_err_o,
    output logic [15:0]            calc_crc_o,
    output logic [15:0]            rx_crc_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DATA = 1'b1;

    // Reflected x^16+x^12+x^5+1, data consumed LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int k = 0; k < 8; k++) begin
            fb = c[0] ^ b[k];
            c  = {1'b0, c[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
        end
        return c;
    endfunction

    logic [0:0]  state_q, state_d;
    logic [16:0] rem_q,   rem_d;
    logic [15:0] crc_q,   crc_d;
    logic [15:0] rx_q,    rx_d;
    logic        err_q,   err_d;
    logic        ok_q,    ok_d;
    logic        short_q, short_d;
    logic        trunc_q, trunc_d;

    logic [5:0]  hdr_dt;
    logic [15:0] hdr_wc;
    logic [7:0]  lane_byte;

    assign hdr_dt = pkt_if.pkt_data[5:0];
    assign hdr_wc = pkt_if.pkt_data[23:8];

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        crc_d     = crc_q;
        rx_d      = rx_q;
        err_d     = 1'b0;
        ok_d      = 1'b0;
        short_d   = 1'b0;
        trunc_d   = 1'b0;
        lane_byte = 8'h00;

        if (pkt_if.pkt_valid) begin
            if (pkt_if.pkt_sop) begin
                trunc_d = (state_q == ST_DATA);
                if (hdr_dt < LONG_DT_MIN) begin
                    short_d = 1'b1;
                    state_d = ST_IDLE;
                    rem_d   = 17'd0;
                end else begin
                    rem_d   = 17'(hdr_wc) + 17'd2;
                    crc_d   = CRC_INIT;
                    rx_d    = 16'h0000;
                    state_d = ST_DATA;
                end
            end else if (state_q == ST_DATA) begin
                // Lane role follows from bytes still owed: >2 payload, 2 CRC-lo, 1 CRC-hi, else unused.
                for (int i = 0; i < 4; i++) begin
                    lane_byte = pkt_if.pkt_data[8*i +: 8];
                    if (rem_q > 17'(i + 2)) begin
                        crc_d = crc16_byte(crc_d, lane_byte);
                    end else if (rem_q == 17'(i + 2)) begin
                        rx_d[7:0] = lane_byte;
                    end else if (rem_q == 17'(i + 1)) begin
                        rx_d[15:8] = lane_byte;
                    end
                end
                if (rem_q <= 17'd4) begin
                    rem_d   = 17'd0;
                    state_d = ST_IDLE;
                    ok_d    = (rx_d == crc_d);
                    err_d   = (rx_d != crc_d);
                end else begin
                    rem_d = rem_q - 17'd4;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            rem_q   <= 17'd0;
            crc_q   <= CRC_INIT;
            rx_q    <= 16'h0000;
            err_q   <= 1'b0;
            ok_q    <= 1'b0;
            short_q <= 1'b0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            crc_q   <= crc_d;
            rx_q    <= rx_d;
            err_q   <= err_d;
            ok_q    <= ok_d;
            short_q <= short_d;
            trunc_q <= trunc_d;
        end
    end

    assign crc_err_o   = err_q;
    assign crc_ok_o    = ok_q;
    assign short_pkt_o = short_q;
    assign trunc_err_o = trunc_q;

`ifdef CSI2_CRC_CAPTURE_EN
    logic [15:0] cap_calc_q;
    logic [15:0] cap_rx_q;

    // Loaded together with the crc_err pulse so the pair is visible while it is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cap_calc_q <= 16'h0000;
            cap_rx_q   <= 16'h0000;
        end else if (err_d) begin
            cap_calc_q <= crc_d;
            cap_rx_q   <= rx_d;
        end
    end

    assign calc_crc_o = cap_calc_q;
    assign rx_crc_o   = cap_rx_q;
`else
    assign calc_crc_o = 16'h0000;
    assign rx_crc_o   = 16'h0000;
`endif

endmodule

// File: tb/tb_csi2_crc_check.sv
// Scoreboard bench for csi2_crc_check: driver queues expected pulses, a negedge monitor checks them.
module tb_csi2_crc_check;

    localparam logic [3:0] P_ERR   = 4'b1000;
    localparam logic [3:0] P_OK    = 4'b0100;
    localparam logic [3:0] P_SHORT = 4'b0010;
    localparam logic [3:0] P_TRUNC = 4'b0001;

    typedef struct {
        logic [3:0]  vec;
        logic [15:0] rx;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        crc_err, crc_ok, short_pkt, trunc_err;
    logic [15:0] calc_crc, rx_crc;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t sb[$];

    csi2_crc_check_if bus ();

    csi2_crc_check dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .pkt_if      (bus.slave),
        .crc_err_o   (crc_err),
        .crc_ok_o    (crc_ok),
        .short_pkt_o (short_pkt),
        .trunc_err_o (trunc_err),
        .calc_crc_o  (calc_crc),
        .rx_crc_o    (rx_crc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte-wise reference CRC (reflected 0x8408, seed FFFF, no final XOR).
    function automatic logic [15:0] model_crc(input logic [7:0] d[$]);
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (d[n]) begin
            c = c ^ {8'h00, d[n]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    task automatic beat(input logic [31:0] d, input logic sop,
                        input logic [3:0] exp_vec, input logic [15:0] exp_rx);
        bus.pkt_data  = d;
        bus.pkt_valid = 1'b1;
        bus.pkt_sop   = sop;
        @(posedge clk);
        if (exp_vec != 4'b0000) sb.push_back('{exp_vec, exp_rx, cyc + 1});
        #1;
        bus.pkt_valid = 1'b0;
        bus.pkt_sop   = 1'b0;
        bus.pkt_data  = 32'h0;
    endtask

    task automatic stall(input int max_stall);
        int n;
        n = (max_stall > 0) ? int'($urandom_range(0, max_stall)) : 0;
        if (n > 0) begin
            repeat (n) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_packet(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] pl[$],
                               input logic [15:0] crc, input int max_stall, input logic [3:0] hdr_vec,
                               input logic [3:0] exp_vec, input logic [15:0] exp_rx);
        logic [7:0] s[$];
        int nb;
        s = pl;
        s.push_back(crc[7:0]);
        s.push_back(crc[15:8]);
        while (s.size() % 4 != 0) s.push_back(8'h5A);
        nb = s.size() / 4;
        beat({8'h00, wc[15:8], wc[7:0], di}, 1'b1, hdr_vec, 16'h0);
        for (int b = 0; b < nb; b++) begin
            stall(max_stall);
            beat({s[4*b+3], s[4*b+2], s[4*b+1], s[4*b]}, 1'b0,
                 (b == nb - 1) ? exp_vec : 4'b0000, exp_rx);
        end
    endtask

    always @(negedge clk) begin
        exp_t       e;
        logic [3:0] got;
        cyc++;
        got = {crc_err, crc_ok, short_pkt, trunc_err};
        if (got != 4'b0000) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: got err/ok/short/trunc=%b at cycle %0d, required none", got, cyc);
            end else begin
                e = sb.pop_front();
                if (got !== e.vec || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL pulse: got err/ok/short/trunc=%b at cycle %0d, required %b at cycle %0d",
                             got, cyc, e.vec, e.cyc);
                end
`ifdef CSI2_CRC_CAPTURE_EN
                if (e.vec[3]) begin
                    checks++;
                    if (rx_crc !== e.rx || calc_crc === e.rx) begin
                        errors++;
                        $display("FAIL capture: got rx=%h calc=%h, required rx=%h calc!=%h",
                                 rx_crc, calc_crc, e.rx, e.rx);
                    end
                end
`else
                checks++;
                if (rx_crc !== 16'h0 || calc_crc !== 16'h0) begin
                    errors++;
                    $display("FAIL capture_off: got rx=%h calc=%h, required 0000 0000", rx_crc, calc_crc);
                end
`endif
            end
        end
    end

    initial begin
        logic [7:0] pa[$];
        logic [7:0] pb[$];
        logic [7:0] p5[$];
        logic [7:0] p8[$];
        logic [7:0] p4[$];
        logic [7:0] none[$];

        pa = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72, 8'hBB, 8'hD4, 8'hB8, 8'h5A,
               8'hC8, 8'h75, 8'hC2, 8'h7C, 8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};
        pb = pa;
        pb[5] = 8'hDD;
        p5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        p8 = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};
        p4 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        rst_n         = 1'b0;
        bus.pkt_data  = 32'h0;
        bus.pkt_valid = 1'b0;
        bus.pkt_sop   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_crc_err", {31'b0, crc_err}, 32'd0);
        chk("reset_crc_ok", {31'b0, crc_ok}, 32'd0);
        chk("reset_short", {31'b0, short_pkt}, 32'd0);
        chk("reset_trunc", {31'b0, trunc_err}, 32'd0);
        chk("reset_calc", {16'b0, calc_crc}, 32'd0);
        chk("reset_rx", {16'b0, rx_crc}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Reference 24-byte packet, checksum 0x00F0.
        send_packet(8'h2A, 16'h0018, pa, 16'h00F0, 0, 4'b0000, P_OK, 16'h0);
        send_packet(8'h2A, 16'h0018, pb, 16'h00F0, 0, 4'b0000, P_ERR, 16'h00F0);

        // Empty payload: computed CRC stays at the seed.
        send_packet(8'h2A, 16'h0000, none, 16'hFFFF, 0, 4'b0000, P_OK, 16'h0);
        send_packet(8'h2A, 16'h0000, none, 16'hFFFE, 0, 4'b0000, P_ERR, 16'hFFFE);

        // Odd length with stalls; lane 3 of the final beat is filler.
        send_packet(8'h2B, 16'h0005, p5, model_crc(p5), 3, 4'b0000, P_OK, 16'h0);
        send_packet(8'h2B, 16'h0005, p5, model_crc(p5) ^ 16'h8000, 3, 4'b0000, P_ERR, model_crc(p5) ^ 16'h8000);

        // Non-sop beat in IDLE is ignored; short header in IDLE pulses short only.
        beat(32'h1234_5678, 1'b0, 4'b0000, 16'h0);
        beat(32'h00_0000_01, 1'b1, P_SHORT, 16'h0);

        // Long packet cut short by a short header.
        beat({8'h00, 8'h00, 8'h64, 8'h2A}, 1'b1, 4'b0000, 16'h0);
        beat(32'hAAAA_AAAA, 1'b0, 4'b0000, 16'h0);
        beat(32'hBBBB_BBBB, 1'b0, 4'b0000, 16'h0);
        beat(32'hCCCC_CCCC, 1'b0, 4'b0000, 16'h0);
        beat(32'h0000_0000, 1'b1, P_SHORT | P_TRUNC, 16'h0);
        send_packet(8'h2A, 16'h0008, p8, model_crc(p8), 0, 4'b0000, P_OK, 16'h0);

        // Long packet cut short by another long header, which then completes.
        beat({8'h00, 8'h00, 8'h08, 8'h2A}, 1'b1, 4'b0000, 16'h0);
        beat(32'h1111_1111, 1'b0, 4'b0000, 16'h0);
        send_packet(8'h2C, 16'h0004, p4, model_crc(p4), 1, P_TRUNC, P_OK, 16'h0);

        // Asynchronous reset mid-payload aborts silently.
        beat({8'h00, 8'h00, 8'h08, 8'h2A}, 1'b1, 4'b0000, 16'h0);
        beat(32'h0102_0304, 1'b0, 4'b0000, 16'h0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        beat(32'h0506_0708, 1'b0, 4'b0000, 16'h0);
        send_packet(8'h2A, 16'h0008, p8, model_crc(p8), 2, 4'b0000, P_OK, 16'h0);

        repeat (8) @(posedge clk);
        #1;
        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/csi2_crc_check.md
Name: csi2_crc_check

Overview:
- Monitors the depacketised CSI-2 byte stream (4 byte lanes per beat) and tracks packet boundaries from the long-packet header word count.
- Computes CSI-2 CRC-16 over each long-packet payload and compares it against the received 2-byte checksum.
- Sits directly upstream of csi2_stat_acc and drives its crc_err input with a single-cycle pulse per failing packet.
- Pure sniffer: no back-pressure, no data modification.

Parameters:
- CRC_INIT, 16'hFFFF, CRC seed loaded at every header.
- LONG_DT_MIN, 6'h10, smallest data type treated as a long packet; DT below this is a short packet.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- pkt_data_i  in  32  beat data; byte 0 in [7:0], byte 3 in [31:24]
- pkt_valid_i  in  1  beat qualifier
- pkt_sop_i  in  1  beat is a packet header (valid only with pkt_valid_i)
- crc_err_o  out  1  pulse: long-packet CRC mismatch
- crc_ok_o  out  1  pulse: long-packet CRC match
- short_pkt_o  out  1  pulse: short-packet header seen
- trunc_err_o  out  1  pulse: new header arrived before the previous packet completed
- calc_crc_o  out  16  computed CRC (optional feature)
- rx_crc_o  out  16  received CRC (optional feature)

Behaviour:
- Reset: state IDLE, all outputs 0, rem_bytes 0, crc reg = CRC_INIT.
- Header beat layout:
  - DI = [7:0], DT = DI[5:0].
  - WC = [23:8], little-endian.
  - ECC = [31:24], ignored here.
- FSM: IDLE, DATA. Beats with pkt_valid_i=0 are stalls; state and registers hold.
- IDLE:
  - Beat with sop and DT < LONG_DT_MIN: short_pkt_o pulses next cycle; stay IDLE.
  - Beat with sop and DT >= LONG_DT_MIN: rem_bytes <= WC+2 (17-bit, max 0x10001), crc <= CRC_INIT, go to DATA.
  - Non-sop beats are ignored.
- DATA, non-sop beat, lanes 0..3 processed in order, position p = consumed-so-far:
  - Lane is payload while p < WC: fed through CRC.
  - Lane is CRC-lo at p = WC and CRC-hi at p = WC+1: captured, little-endian.
  - Any later lane is unused and ignored.
  - rem_bytes decrements by min(4, rem_bytes).
- Completion: when the beat takes rem_bytes to 0:
  - Compare captured CRC with computed CRC.
  - crc_ok_o or crc_err_o pulses in the next cycle (latency 1 cycle after the final CRC beat).
  - Return to IDLE.
- CRC algorithm:
  - Polynomial x^16+x^12+x^5+1, reflected form 0x8408, LSB-first per byte, no final XOR.
  - Up to 4 bytes per cycle via a combinational chain with per-lane enables.
- WC=0: no payload bytes. The computed CRC stays CRC_INIT; the next beat supplies the CRC in lanes 0 and 1.
- sop beat while in DATA:
  - trunc_err_o pulses next cycle; the old packet is abandoned with no crc_ok/crc_err.
  - The sop beat is decoded as a fresh header, same cycle.
- All pulses are exactly 1 cycle. At most one of crc_ok_o/crc_err_o per packet, mutually exclusive.
- Asynchronous reset mid-packet forces IDLE immediately; no pulses are generated for the aborted packet.

Optional Feature:
- Macro: CSI2_CRC_CAPTURE_EN.
- Defined: calc_crc_o and rx_crc_o update on every crc_err_o pulse and hold the last failing pair until reset.
- Undefined: capture registers are not built; both ports are driven constant 0.
- crc_err_o timing and function are identical either way.

Test Plan:
- Header DI=0x2A, WC=0x0018; payload FF 00 00 02 B9 DC F3 72 BB D4 B8 5A C8 75 C2 7C 81 F8 05 DF FF 00 00 01; CRC beat lanes0-1 = F0 00 -> crc_ok_o pulse 1 cycle after CRC beat, crc_err_o stays 0.
- Same packet with payload byte 5 flipped to 0xDD -> crc_err_o single pulse. With macro: rx_crc_o=0x00F0 and calc_crc_o != 0x00F0.
- WC=0 header, next beat FF FF xx xx -> crc_ok_o. Same with CRC bytes FE FF -> crc_err_o.
- WC=5, random stalls (pkt_valid_i low 0-3 cycles between beats):
  - Payload spans 4 bytes plus lane 0; CRC in lanes 1-2; lane 3 garbage is ignored.
  - Result matches the software CRC model.
- Long header WC=100, 3 payload beats, then sop with DI=0x00 (short) -> trunc_err_o pulse and short_pkt_o pulse, no crc pulse. A following WC=8 packet checks correctly.
- rst_n_i low mid-payload for 1 cycle -> no pulses. The next complete valid packet gives crc_ok_o.
